bus_uart_bridge: RTL and testbench
==================================

BUS_UART_BRIDGE -- requirements
Module: bus_uart_bridge

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- N, 8, data word width; N >= 8.
- ADN, 12, address length in bits; ADN > N.
- BN, 3, burst-length code width.
- TX_DEPTH, 16, TX FIFO depth in words; power of 2.
- RX_DEPTH, 16, RX FIFO depth in words; power of 2.
- STATUS_ADDR, all-ones (ADN bits), address of the status word.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- validIn, in, 1, serial bus bit valid.
- wren, in, 1, 1 = write, 0 = read; sampled at transaction start.
- Address, in, 1, serial address bit, MSB first.
- DataIn, in, 1, serial write data bit, MSB first.
- BurstEn, in, 1, burst flag at start; burst-code bit during the last BN address cycles.
- BusAvailable, in, 1, read return path granted.
- uart_busy, in, 1, UART transmitter busy.
- rx_valid, in, 1, received UART word strobe.
- rx_data, in, N, received UART word.
- state_out, out, 4, current FSM state.
- to_uart, out, N, word presented to the UART.
- tx_external, out, 1, one-cycle UART load strobe.
- ready, out, 1, slave ready for the bus.
- hold, out, 1, stalls the bus master.
- validOut, out, 1, serial read bit valid.
- DataOut, out, 1, serial read bit, MSB first.
- tx_overflow, out, 1, sticky: TX FIFO was full on a push attempt.
- rx_overflow, out, 1, sticky: rx_valid arrived while the RX FIFO was full.

Function
REQ-003 FSM states SHALL be IDLE=0, ADWR=1, AD=2, WPUSH=3, BWR=4, RDWAIT=5, RD=6; state_out SHALL equal the current state.
REQ-004 IDLE SHALL assert ready=1. On validIn=1 it SHALL clear all counters, latch wren and BurstEn, and go to ADWR (wren=1) or AD (wren=0); the Address bit of that same cycle SHALL be address bit 1.
REQ-005 Address phase: one Address bit SHALL be shifted in per cycle with validIn=1, ADN bits in total; cycles with validIn=0 SHALL be ignored. When burst, BurstEn in the last BN address cycles SHALL form code L, MSB first, and the burst length SHALL be 2^L words; when not burst, the length SHALL be 1 word.
REQ-006 ADWR: DataIn SHALL be shifted in during the last N address cycles. After bit ADN the FSM SHALL go to WPUSH.
REQ-007 WPUSH: if the TX FIFO is not full, it SHALL push the word and decrement the remaining-word count. It SHALL then go to BWR if words remain, else to IDLE.
REQ-008 WPUSH with the TX FIFO full SHALL assert hold=1 and set tx_overflow. It SHALL wait in WPUSH with no data lost and push once space exists.
REQ-009 BWR: ready=1; N DataIn bits SHALL be shifted in on validIn cycles, then the FSM SHALL go to WPUSH.
REQ-010 AD: after ADN bits the FSM SHALL go to RDWAIT.
REQ-011 RDWAIT SHALL go to RD when BusAvailable=1 and either the address equals STATUS_ADDR or the RX FIFO is non-empty. While waiting only for RX data it SHALL assert hold=1.
REQ-012 RD: the word SHALL be loaded on the entry cycle, either popped from the RX FIFO or the status word. It SHALL then be driven for N consecutive cycles with validOut=1, DataOut MSB first. Afterwards validOut=0 and DataOut=0; the FSM SHALL go to RDWAIT if burst words remain, else to IDLE.
REQ-013 Status word SHALL be {tx_full, tx_empty, rx_full, rx_empty, rx_overflow, tx_overflow, zeros}, left-aligned in N bits. Loading it SHALL clear both sticky flags in that cycle.
REQ-014 TX drain SHALL run concurrently with the FSM. When the TX FIFO is non-empty, uart_busy=0 and tx_external=0, it SHALL drive to_uart=head, set tx_external=1 for exactly one cycle and pop. to_uart SHALL hold its value until the next load.
REQ-015 RX fill: rx_valid=1 with the RX FIFO not full SHALL push rx_data. If the FIFO is full the word SHALL be dropped and rx_overflow set.
REQ-016 A same-cycle push and pop on one FIFO SHALL both succeed, including when it is full or empty. Pointers SHALL wrap modulo depth, and occupancy SHALL use log2(depth)+1 bits.

Reset
REQ-017 With reset=0: state=IDLE, both FIFOs empty, all outputs 0 except ready=1, counters cleared. This SHALL apply immediately, including mid-transaction; the partial word SHALL be discarded.

Structure
REQ-018 A shared package SHALL hold the state encodings and the status bit indices.
REQ-019 One sub-module, sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-020 Single write: address 0x123, data 0xA5, uart_busy=0 -> one tx_external pulse with to_uart=0xA5; FIFO returns to empty.
REQ-021 Burst write with L=2 and uart_busy=1 -> 4 words held in the TX FIFO; releasing uart_busy -> 4 pulses in order.
REQ-022 17 writes with uart_busy=1 and TX_DEPTH=16 -> hold asserted on the 17th; tx_overflow=1; the 17th word is transmitted after a drain.
REQ-023 rx_data=0x3C pushed, then read of address 0x010 -> 8 validOut cycles carrying 0,0,1,1,1,1,0,0.
REQ-024 Read of STATUS_ADDR after an RX overflow -> bit 3 = 1; a second status read -> bit 3 = 0.
REQ-025 reset=0 in the middle of a BWR burst -> next cycle state_out=0, ready=1, FIFOs empty.

Source files
------------

// File: rtl/bus_uart_bridge_pkg.sv
// Shared encodings for the serial-bus to UART bridge: FSM states and the
// bit positions of the status word.
package bus_uart_bridge_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] S_ADWR   = 4'd1;
    localparam logic [STATE_W-1:0] S_AD     = 4'd2;
    localparam logic [STATE_W-1:0] S_WPUSH  = 4'd3;
    localparam logic [STATE_W-1:0] S_BWR    = 4'd4;
    localparam logic [STATE_W-1:0] S_RDWAIT = 4'd5;
    localparam logic [STATE_W-1:0] S_RD     = 4'd6;

    // Status bit positions, counted down from the MSB of the data word
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_TX_OVF   = 5;

endpackage

// File: rtl/bus_uart_bridge_if.sv
// Serial bus bundle between a bus master and the bridge.
interface bus_uart_bridge_if;
    import bus_uart_bridge_pkg::*;

    // A bit transfers on every rising edge with validIn=1. ready=1 marks the
    // states where a transaction or a burst word may be offered; hold=1 asks
    // the master to stall; validOut=1 qualifies each returned DataOut bit.
    logic                validIn;
    logic                wren;
    logic                Address;
    logic                DataIn;
    logic                BurstEn;
    logic                BusAvailable;
    logic                ready;
    logic                hold;
    logic                validOut;
    logic                DataOut;
    logic [STATE_W-1:0]  state_out;

    modport master (
        output validIn, wren, Address, DataIn, BurstEn, BusAvailable,
        input  ready, hold, validOut, DataOut, state_out
    );

    modport slave (
        input  validIn, wren, Address, DataIn, BurstEn, BusAvailable,
        output ready, hold, validOut, DataOut, state_out
    );

endinterface

// File: rtl/bus_uart_bridge_fifo.sv
// Synchronous FIFO with combinational head; push and pop in the same cycle
// both succeed, including when full (overwrite of the slot being read) or empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             bypass, wr_en, rd_en;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    // Push and pop on an empty FIFO hand the word straight through
    assign bypass = empty && push && pop;
    assign wr_en  = push && (!full || pop) && !bypass;
    assign rd_en  = pop && !empty;
    assign rdata  = empty ? wdata : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (rd_en) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/bus_uart_bridge.sv
// Bridge from a bit-serial memory bus to a UART: writes queue words for the
// transmitter, reads return received words or a status word.
module bus_uart_bridge
    import bus_uart_bridge_pkg::*;
#(
    parameter int             N           = 8,
    parameter int             ADN         = 12,
    parameter int             BN          = 3,
    parameter int             TX_DEPTH    = 16,
    parameter int             RX_DEPTH    = 16,
    parameter logic [ADN-1:0] STATUS_ADDR = {ADN{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                validIn,
    input  logic                wren,
    input  logic                Address,
    input  logic                DataIn,
    input  logic                BurstEn,
    input  logic                BusAvailable,
    input  logic                uart_busy,
    input  logic                rx_valid,
    input  logic [N-1:0]        rx_data,
    output logic [STATE_W-1:0]  state_out,
    output logic [N-1:0]        to_uart,
    output logic                tx_external,
    output logic                ready,
    output logic                hold,
    output logic                validOut,
    output logic                DataOut,
    output logic                tx_overflow,
    output logic                rx_overflow
);
    localparam int AW  = $clog2(ADN + 1);
    localparam int DW  = $clog2(N + 1);
    localparam int WCW = (1 << BN) + 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADN-1:0]     addr_q, addr_d;
    logic [AW-1:0]      acnt_q, acnt_d, acnt_nx;
    logic [N-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]      dcnt_q, dcnt_d, dcnt_nx;
    logic [BN-1:0]      lcode_q, lcode_d;
    logic [WCW-1:0]     words_q, words_d;
    logic               burst_q, burst_d;
    logic [N-1:0]       rd_sh_q, rd_sh_d;
    logic               tx_ovf_q, rx_ovf_q;
    logic [N-1:0]       to_uart_q;
    logic               tx_ext_q;

    logic               tx_push, tx_pop, tx_full, tx_empty;
    logic               rx_push, rx_pop, rx_full, rx_empty;
    logic [N-1:0]       tx_head, rx_head, status_word;
    logic               status_load, is_status;

    sync_fifo #(.WIDTH(N), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .wdata(wdata_q), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(N), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .wdata(rx_data), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign is_status = (addr_q == STATUS_ADDR);
    assign tx_pop    = !tx_empty && !uart_busy && !tx_ext_q;
    assign rx_push   = rx_valid && !rx_full;

    always_comb begin
        status_word = '0;
        status_word[N-1-ST_TX_FULL]  = tx_full;
        status_word[N-1-ST_TX_EMPTY] = tx_empty;
        status_word[N-1-ST_RX_FULL]  = rx_full;
        status_word[N-1-ST_RX_EMPTY] = rx_empty;
        status_word[N-1-ST_RX_OVF]   = rx_ovf_q;
        status_word[N-1-ST_TX_OVF]   = tx_ovf_q;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acnt_d      = acnt_q;
        wdata_d     = wdata_q;
        dcnt_d      = dcnt_q;
        lcode_d     = lcode_q;
        words_d     = words_q;
        burst_d     = burst_q;
        rd_sh_d     = rd_sh_q;
        tx_push     = 1'b0;
        rx_pop      = 1'b0;
        status_load = 1'b0;
        acnt_nx     = acnt_q + AW'(1);
        dcnt_nx     = dcnt_q + DW'(1);
        case (state_q)
            S_IDLE: begin
                if (validIn) begin
                    burst_d = BurstEn;
                    addr_d  = ADN'(Address);
                    acnt_d  = AW'(1);
                    wdata_d = '0;
                    dcnt_d  = '0;
                    lcode_d = '0;
                    words_d = '0;
                    state_d = wren ? S_ADWR : S_AD;
                end
            end
            S_ADWR, S_AD: begin
                if (validIn) begin
                    addr_d = ADN'({addr_q, Address});
                    acnt_d = acnt_nx;
                    if (state_q == S_ADWR && acnt_nx > AW'(ADN - N))
                        wdata_d = N'({wdata_q, DataIn});
                    if (acnt_nx > AW'(ADN - BN))
                        lcode_d = BN'({lcode_q, BurstEn});
                    if (acnt_nx == AW'(ADN)) begin
                        words_d = burst_q ? (WCW'(1) << lcode_d) : WCW'(1);
                        state_d = (state_q == S_ADWR) ? S_WPUSH : S_RDWAIT;
                    end
                end
            end
            S_WPUSH: begin
                if (!tx_full) begin
                    tx_push = 1'b1;
                    words_d = words_q - WCW'(1);
                    dcnt_d  = '0;
                    state_d = (words_q != WCW'(1)) ? S_BWR : S_IDLE;
                end
            end
            S_BWR: begin
                if (validIn) begin
                    wdata_d = N'({wdata_q, DataIn});
                    dcnt_d  = dcnt_nx;
                    if (dcnt_nx == DW'(N)) state_d = S_WPUSH;
                end
            end
            S_RDWAIT: begin
                if (BusAvailable && (is_status || !rx_empty)) begin
                    dcnt_d  = '0;
                    state_d = S_RD;
                    if (is_status) begin
                        rd_sh_d     = status_word;
                        status_load = 1'b1;
                    end else begin
                        rd_sh_d = rx_head;
                        rx_pop  = 1'b1;
                    end
                end
            end
            S_RD: begin
                rd_sh_d = {rd_sh_q[N-2:0], 1'b0};
                dcnt_d  = dcnt_nx;
                if (dcnt_nx == DW'(N)) begin
                    words_d = words_q - WCW'(1);
                    state_d = (words_q != WCW'(1)) ? S_RDWAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            acnt_q   <= '0;
            wdata_q  <= '0;
            dcnt_q   <= '0;
            lcode_q  <= '0;
            words_q  <= '0;
            burst_q  <= 1'b0;
            rd_sh_q  <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            acnt_q   <= acnt_d;
            wdata_q  <= wdata_d;
            dcnt_q   <= dcnt_d;
            lcode_q  <= lcode_d;
            words_q  <= words_d;
            burst_q  <= burst_d;
            rd_sh_q  <= rd_sh_d;
            // A new overflow in the same cycle as a status load is kept
            tx_ovf_q <= (state_q == S_WPUSH && tx_full) || (tx_ovf_q && !status_load);
            rx_ovf_q <= (rx_valid && rx_full) || (rx_ovf_q && !status_load);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_uart_q <= '0;
            tx_ext_q  <= 1'b0;
        end else begin
            tx_ext_q <= tx_pop;
            if (tx_pop) to_uart_q <= tx_head;
        end
    end

    assign state_out   = state_q;
    assign to_uart     = to_uart_q;
    assign tx_external = tx_ext_q;
    assign ready       = (state_q == S_IDLE) || (state_q == S_BWR);
    assign hold        = (state_q == S_WPUSH && tx_full) ||
                         (state_q == S_RDWAIT && !is_status && rx_empty);
    assign validOut    = (state_q == S_RD);
    assign DataOut     = (state_q == S_RD) && rd_sh_q[N-1];
    assign tx_overflow = tx_ovf_q;
    assign rx_overflow = rx_ovf_q;

endmodule

// File: tb/tb_bus_uart_bridge.sv
// Directed bench for bus_uart_bridge: drivers push expected UART words and
// read words into queues, a negedge monitor checks them as the DUT emits them.
module tb_bus_uart_bridge;
    import bus_uart_bridge_pkg::*;

    localparam int N   = 8;
    localparam int ADN = 12;
    localparam int BN  = 3;
    localparam logic [ADN-1:0] STATUS = {ADN{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         uart_busy, rx_valid;
    logic [N-1:0] rx_data;
    logic [N-1:0] to_uart;
    logic         tx_external, tx_overflow, rx_overflow;

    bus_uart_bridge_if bus_if ();

    bus_uart_bridge #(.N(N), .ADN(ADN), .BN(BN), .TX_DEPTH(16), .RX_DEPTH(16),
                      .STATUS_ADDR(STATUS)) dut (
        .clk(clk), .reset(reset),
        .validIn(bus_if.validIn), .wren(bus_if.wren), .Address(bus_if.Address),
        .DataIn(bus_if.DataIn), .BurstEn(bus_if.BurstEn),
        .BusAvailable(bus_if.BusAvailable), .uart_busy(uart_busy),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .state_out(bus_if.state_out), .to_uart(to_uart), .tx_external(tx_external),
        .ready(bus_if.ready), .hold(bus_if.hold), .validOut(bus_if.validOut),
        .DataOut(bus_if.DataOut), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [N-1:0] exp_tx_q[$];
    logic [N-1:0] exp_rd_q[$];
    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;
    int rd_bit_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            rd_bit_idx = 0;
        end else begin
            if (tx_external) begin
                tx_pulses++;
                if (exp_tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", to_uart);
                end else begin
                    check("tx_word", to_uart, exp_tx_q.pop_front());
                end
            end
            if (bus_if.validOut) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got bit %0b expected none", bus_if.DataOut);
                end else begin
                    check("rd_bit", bus_if.DataOut, exp_rd_q[0][N-1-rd_bit_idx]);
                    rd_bit_idx++;
                    if (rd_bit_idx == N) begin
                        void'(exp_rd_q.pop_front());
                        rd_bit_idx = 0;
                    end
                end
            end else if (rd_bit_idx != 0) begin
                checks++; errors++;
                $display("FAIL rd_short: got %0d bits expected %0d", rd_bit_idx, N);
                rd_bit_idx = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic wr, input logic [ADN-1:0] a, input logic burst,
                             input logic [BN-1:0] l, input logic [N-1:0] d0);
        for (int k = 1; k <= ADN; k++) begin
            bus_if.validIn = 1'b1;
            bus_if.wren    = wr;
            bus_if.Address = a[ADN-k];
            bus_if.DataIn  = (k > ADN - N) ? d0[N-1-(k-(ADN-N+1))] : 1'b0;
            if (k == 1)             bus_if.BurstEn = burst;
            else if (k > ADN - BN)  bus_if.BurstEn = l[BN-1-(k-(ADN-BN+1))];
            else                    bus_if.BurstEn = 1'b0;
            cyc();
        end
        bus_if.validIn = 1'b0;
        bus_if.BurstEn = 1'b0;
        bus_if.DataIn  = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] d);
        for (int b = N - 1; b >= 0; b--) begin
            bus_if.validIn = 1'b1;
            bus_if.DataIn  = d[b];
            cyc();
        end
        bus_if.validIn = 1'b0;
        bus_if.DataIn  = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        bus_if.validIn = 1'b0;
        n = 0;
        while (!bus_if.ready && n < budget) begin
            cyc();
            n++;
        end
        if (!bus_if.ready) begin
            checks++; errors++;
            $display("FAIL %s timeout: ready=0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic bus_write(input logic [ADN-1:0] a, input logic burst, input logic [BN-1:0] l,
                             input logic [N-1:0] w [16], input int n);
        for (int i = 0; i < n; i++) exp_tx_q.push_back(w[i]);
        send_addr(1'b1, a, burst, l, w[0]);
        wait_ready("wr_push", 300);
        for (int i = 1; i < n; i++) begin
            send_word(w[i]);
            wait_ready("wr_push", 300);
        end
    endtask

    task automatic bus_read(input logic [ADN-1:0] a, input logic burst, input logic [BN-1:0] l);
        send_addr(1'b0, a, burst, l, '0);
        wait_ready("rd_done", 400);
    endtask

    task automatic read_status(input logic [N-1:0] exp);
        exp_rd_q.push_back(exp);
        bus_read(STATUS, 1'b0, '0);
    endtask

    task automatic rx_send(input logic [N-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        cyc();
        rx_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] wbuf [16];
    int           pulses_before;

    initial begin
        reset = 1'b0;
        uart_busy = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        bus_if.validIn = 1'b0;
        bus_if.wren = 1'b0;
        bus_if.Address = 1'b0;
        bus_if.DataIn = 1'b0;
        bus_if.BurstEn = 1'b0;
        bus_if.BusAvailable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", bus_if.state_out, S_IDLE);
        check("rst_ready", bus_if.ready, 1'b1);
        check("rst_hold", bus_if.hold, 1'b0);
        check("rst_validOut", bus_if.validOut, 1'b0);
        check("rst_DataOut", bus_if.DataOut, 1'b0);
        check("rst_tx_ext", tx_external, 1'b0);
        check("rst_to_uart", to_uart, 8'h00);
        check("rst_ovf", {tx_overflow, rx_overflow}, 2'b00);
        cyc();
        reset = 1'b1;
        cyc();

        // single write, transmitter idle
        wbuf[0] = 8'hA5;
        bus_write(12'h123, 1'b0, '0, wbuf, 1);
        repeat (6) cyc();
        check("single_drained", exp_tx_q.size(), 0);
        read_status(8'h50);

        // burst of 4 held while the UART is busy
        uart_busy = 1'b1;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        pulses_before = tx_pulses;
        bus_write(12'h040, 1'b1, 3'd2, wbuf, 4);
        read_status(8'h10);
        check("burst_held_pulses", tx_pulses - pulses_before, 0);
        check("burst_held_queue", exp_tx_q.size(), 4);
        uart_busy = 1'b0;
        repeat (20) cyc();
        check("burst_pulses", tx_pulses - pulses_before, 4);

        // 17 writes into a 16-deep TX FIFO
        uart_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wbuf[0] = 8'h50 + 8'(i);
            bus_write(12'h200 + 12'(i), 1'b0, '0, wbuf, 1);
        end
        check("fill_hold", bus_if.hold, 1'b0);
        check("fill_tx_ovf", tx_overflow, 1'b0);
        wbuf[0] = 8'h60;
        fork
            bus_write(12'h210, 1'b0, '0, wbuf, 1);
            begin
                repeat (ADN + 4) @(negedge clk);
                check("full_hold", bus_if.hold, 1'b1);
                check("full_state", bus_if.state_out, S_WPUSH);
                check("full_tx_ovf", tx_overflow, 1'b1);
                uart_busy = 1'b0;
            end
        join
        repeat (60) cyc();
        check("full_drained", exp_tx_q.size(), 0);
        read_status(8'h54);
        check("tx_ovf_cleared", tx_overflow, 1'b0);
        read_status(8'h50);

        // read of a received word, then a read that waits for RX data
        rx_send(8'h3C);
        exp_rd_q.push_back(8'h3C);
        bus_read(12'h010, 1'b0, '0);
        exp_rd_q.push_back(8'hC3);
        fork
            bus_read(12'h010, 1'b0, '0);
            begin
                repeat (ADN + 3) @(negedge clk);
                check("rd_wait_hold", bus_if.hold, 1'b1);
                check("rd_wait_state", bus_if.state_out, S_RDWAIT);
                rx_send(8'hC3);
            end
        join

        // RX overflow and status read-to-clear
        for (int i = 0; i < 17; i++) rx_send(8'h80 + 8'(i));
        check("rx_ovf_set", rx_overflow, 1'b1);
        read_status(8'h68);
        check("rx_ovf_cleared", rx_overflow, 1'b0);
        read_status(8'h60);
        for (int i = 0; i < 16; i++) exp_rd_q.push_back(8'h80 + 8'(i));
        bus_read(12'h020, 1'b1, 3'd4);
        read_status(8'h50);

        // reset in the middle of a burst word
        uart_busy = 1'b1;
        send_addr(1'b1, 12'h0AB, 1'b1, 3'd1, 8'h11);
        wait_ready("bwr_enter", 50);
        check("bwr_state", bus_if.state_out, S_BWR);
        for (int b = 0; b < 3; b++) begin
            bus_if.validIn = 1'b1;
            bus_if.DataIn  = 1'b1;
            cyc();
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_state", bus_if.state_out, S_IDLE);
        check("midrst_ready", bus_if.ready, 1'b1);
        check("midrst_hold", bus_if.hold, 1'b0);
        check("midrst_tx_ext", tx_external, 1'b0);
        bus_if.validIn = 1'b0;
        bus_if.DataIn  = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        read_status(8'h50);
        uart_busy = 1'b0;
        repeat (10) cyc();

        check("end_tx_queue", exp_tx_q.size(), 0);
        check("end_rd_queue", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
